// File: rtl/cpu_pkg.sv
// cpu_pkg: shared definitions for the CPU control path.
//   state_e     - control FSM state encoding
//   OP_*        - 4-bit opcode values (instr[9:6])
//   ALU_*       - 3-bit ALU function codes driven on alu_op
//   alu_for_op  - maps an ALU-class opcode to its ALU function code
//   is_illegal_op - flags the unassigned opcode range A..E
package cpu_pkg;

  typedef enum logic [2:0] {
    RESET_ST = 3'd0,
    FETCH    = 3'd1,
    DECODE   = 3'd2,
    EXEC     = 3'd3,
    MEM      = 3'd4,
    HALT     = 3'd5
  } state_e;

  localparam logic [3:0] OP_NOP = 4'h0;
  localparam logic [3:0] OP_LDI = 4'h1;
  localparam logic [3:0] OP_ADD = 4'h2;
  localparam logic [3:0] OP_SUB = 4'h3;
  localparam logic [3:0] OP_AND = 4'h4;
  localparam logic [3:0] OP_OR  = 4'h5;
  localparam logic [3:0] OP_JMP = 4'h6;
  localparam logic [3:0] OP_JZ  = 4'h7;
  localparam logic [3:0] OP_LD  = 4'h8;
  localparam logic [3:0] OP_ST  = 4'h9;
  localparam logic [3:0] OP_HLT = 4'hF;

  localparam logic [2:0] ALU_PASS = 3'b000;
  localparam logic [2:0] ALU_ADD  = 3'b001;
  localparam logic [2:0] ALU_SUB  = 3'b010;
  localparam logic [2:0] ALU_AND  = 3'b011;
  localparam logic [2:0] ALU_OR   = 3'b100;

  // LDI passes the immediate straight through, so it shares ALU_PASS.
  function automatic logic [2:0] alu_for_op(input logic [3:0] op);
    case (op)
      OP_ADD:  return ALU_ADD;
      OP_SUB:  return ALU_SUB;
      OP_AND:  return ALU_AND;
      OP_OR:   return ALU_OR;
      default: return ALU_PASS;
    endcase
  endfunction

  function automatic logic is_illegal_op(input logic [3:0] op);
    return (op >= 4'hA) && (op <= 4'hE);
  endfunction

endpackage

// File: rtl/wait_timer.sv
// wait_timer: counts cycles spent waiting on memory and flags a timeout.
//   clk     - system clock
//   rst     - synchronous active-low reset
//   clr     - clear the count to zero (has priority over en)
//   en      - count this cycle
//   expired - count has reached WAIT_MAX; the count saturates there
module wait_timer #(
  parameter int WAIT_MAX = 15
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic expired
);

  localparam int CW = (WAIT_MAX < 1) ? 1 : $clog2(WAIT_MAX + 1);
  localparam logic [CW-1:0] LIMIT = CW'(WAIT_MAX);

  logic [CW-1:0] count_d;
  logic [CW-1:0] count_q;

  assign expired = (count_q == LIMIT);

  // Next count: clear, increment (saturating at LIMIT) or hold.
  always_comb begin
    count_d = count_q;
    if (clr) begin
      count_d = '0;
    end else if (en && !expired) begin
      count_d = count_q + CW'(1);
    end else begin
      count_d = count_q;
    end
  end

  // Count register.
  always_ff @(posedge clk) begin
    if (!rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/control_unit.sv
// control_unit: multi-cycle CPU control FSM (fetch / decode / execute / memory).
//   clk, rst           - clock and synchronous active-low reset
//   instr[9:0]         - IR contents: opcode=[9:6], rsel=[5:4], imm=[3:0]
//   zero_flag          - ALU zero result, used by JZ in EXEC
//   mem_ready          - memory completion strobe
//   IRload/PCinc/PCload, mem_rd/mem_wr, reg_we - control strobes
//   reg_sel[1:0], alu_op[2:0] - register select and ALU function
//   halted/illegal/bus_err    - sticky status flags, cleared only by reset
module control_unit
  import cpu_pkg::*;
#(
  parameter int WAIT_MAX = 15
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [9:0] instr,
  input  logic       zero_flag,
  input  logic       mem_ready,
  output logic       IRload,
  output logic       PCinc,
  output logic       PCload,
  output logic       mem_rd,
  output logic       mem_wr,
  output logic       reg_we,
  output logic [1:0] reg_sel,
  output logic [2:0] alu_op,
  output logic       halted,
  output logic       illegal,
  output logic       bus_err
);

  state_e     state_d, state_q;
  logic       illegal_d, illegal_q;
  logic       halted_d, halted_q;
  logic       bus_err_d, bus_err_q;
  logic       mem_st_d, mem_st_q;
  logic [1:0] mem_rsel_d, mem_rsel_q;

  logic       timer_clr;
  logic       timer_en;
  logic       timer_expired;

  logic [3:0] opcode;
  logic [1:0] rsel;
  logic       unused_imm;

  assign opcode = instr[9:6];
  assign rsel   = instr[5:4];
  // The immediate goes straight to the datapath; the controller never looks at it.
  assign unused_imm = ^instr[3:0];

  assign halted  = halted_q;
  assign illegal = illegal_q;
  assign bus_err = bus_err_q;

  wait_timer #(
    .WAIT_MAX (WAIT_MAX)
  ) u_wait_timer (
    .clk     (clk),
    .rst     (rst),
    .clr     (timer_clr),
    .en      (timer_en),
    .expired (timer_expired)
  );

  // Timer control: count unanswered cycles in FETCH/MEM, zero it everywhere
  // else and on every state change so each wait starts from zero.
  always_comb begin
    timer_clr = 1'b1;
    timer_en  = 1'b0;
    if ((state_q == FETCH) || (state_q == MEM)) begin
      timer_clr = (state_d != state_q);
      timer_en  = !mem_ready;
    end else begin
      timer_clr = 1'b1;
      timer_en  = 1'b0;
    end
  end

  // Next-state, sticky-flag update and state-decoded strobes.
  always_comb begin
    state_d    = state_q;
    illegal_d  = illegal_q;
    halted_d   = halted_q;
    bus_err_d  = bus_err_q;
    mem_st_d   = mem_st_q;
    mem_rsel_d = mem_rsel_q;
    IRload     = 1'b0;
    PCinc      = 1'b0;
    PCload     = 1'b0;
    mem_rd     = 1'b0;
    mem_wr     = 1'b0;
    reg_we     = 1'b0;
    reg_sel    = 2'b00;
    alu_op     = ALU_PASS;

    case (state_q)
      RESET_ST: begin
        state_d = FETCH;
      end

      FETCH: begin
        if (timer_expired) begin
          bus_err_d = 1'b1;
          state_d   = HALT;
        end else if (mem_ready) begin
          // Read request is dropped on the load cycle so IRload never
          // coincides with another bus strobe.
          IRload  = 1'b1;
          PCinc   = 1'b1;
          state_d = DECODE;
        end else begin
          mem_rd = 1'b1;
        end
      end

      DECODE: begin
        state_d = EXEC;
      end

      EXEC: begin
        state_d = FETCH;
        case (opcode)
          OP_NOP: begin
            state_d = FETCH;
          end
          OP_LDI, OP_ADD, OP_SUB, OP_AND, OP_OR: begin
            reg_we  = 1'b1;
            reg_sel = rsel;
            alu_op  = alu_for_op(opcode);
          end
          OP_JMP: begin
            PCload = 1'b1;
          end
          OP_JZ: begin
            if (zero_flag) begin
              PCload = 1'b1;
            end else begin
              PCload = 1'b0;
            end
          end
          OP_LD, OP_ST: begin
            // Capture the direction and target so MEM does not depend on instr.
            mem_st_d   = (opcode == OP_ST);
            mem_rsel_d = rsel;
            state_d    = MEM;
          end
          OP_HLT: begin
            halted_d = 1'b1;
            state_d  = HALT;
          end
          default: begin
            illegal_d = illegal_q | is_illegal_op(opcode);
          end
        endcase
      end

      MEM: begin
        if (timer_expired) begin
          bus_err_d = 1'b1;
          state_d   = HALT;
        end else begin
          mem_rd = !mem_st_q;
          mem_wr = mem_st_q;
          if (mem_ready) begin
            state_d = FETCH;
            if (!mem_st_q) begin
              reg_we  = 1'b1;
              reg_sel = mem_rsel_q;
            end else begin
              reg_we  = 1'b0;
            end
          end else begin
            state_d = MEM;
          end
        end
      end

      HALT: begin
        state_d = HALT;
      end

      default: begin
        state_d = RESET_ST;
      end
    endcase
  end

  // State and sticky-flag registers.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= RESET_ST;
      illegal_q  <= 1'b0;
      halted_q   <= 1'b0;
      bus_err_q  <= 1'b0;
      mem_st_q   <= 1'b0;
      mem_rsel_q <= 2'b00;
    end else begin
      state_q    <= state_d;
      illegal_q  <= illegal_d;
      halted_q   <= halted_d;
      bus_err_q  <= bus_err_d;
      mem_st_q   <= mem_st_d;
      mem_rsel_q <= mem_rsel_d;
    end
  end

endmodule

// File: tb/tb_control_unit.sv
// tb_control_unit: directed-vector bench for control_unit.
// Strobe vector order: {IRload, PCinc, PCload, mem_rd, mem_wr, reg_we}.
module tb_control_unit;

  logic       clk;
  logic       rst;
  logic [9:0] instr;
  logic       zero_flag;
  logic       mem_ready;
  logic       IRload, PCinc, PCload, mem_rd, mem_wr, reg_we;
  logic [1:0] reg_sel;
  logic [2:0] alu_op;
  logic       halted, illegal, bus_err;
  logic [5:0] strb;

  int n_total = 0;
  int n_bad   = 0;

  assign strb = {IRload, PCinc, PCload, mem_rd, mem_wr, reg_we};

  control_unit #(
    .WAIT_MAX (15)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .instr     (instr),
    .zero_flag (zero_flag),
    .mem_ready (mem_ready),
    .IRload    (IRload),
    .PCinc     (PCinc),
    .PCload    (PCload),
    .mem_rd    (mem_rd),
    .mem_wr    (mem_wr),
    .reg_we    (reg_we),
    .reg_sel   (reg_sel),
    .alu_op    (alu_op),
    .halted    (halted),
    .illegal   (illegal),
    .bus_err   (bus_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h expected=%0h @%0t", tag, got, exp, $time);
    end
  endtask

  // Advance one clock and settle just after the edge.
  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  // Called in a FETCH cycle: memory answers at once, then DECODE; returns in EXEC.
  task automatic do_fetch(input logic [9:0] ins);
    mem_ready = 1'b1;
    instr     = ins;
    #1;
    chk("fetch_irload", strb, 6'b110000);
    cyc();
    mem_ready = 1'b0;
    #1;
    chk("decode_quiet", strb, 6'b000000);
    cyc();
  endtask

  initial begin
    rst       = 1'b0;
    instr     = 10'h000;
    zero_flag = 1'b0;
    mem_ready = 1'b0;
    cyc();
    cyc();
    #1;
    chk("rst_strb",    strb,    6'b000000);
    chk("rst_reg_sel", reg_sel, 2'b00);
    chk("rst_alu_op",  alu_op,  3'b000);
    chk("rst_flags",   {halted, illegal, bus_err}, 3'b000);

    // Release: one RESET_ST cycle, then FETCH with mem_ready on its 3rd cycle.
    rst = 1'b1;
    #1;
    chk("reset_st_quiet", strb, 6'b000000);
    cyc();
    #1;
    chk("fetch1_rd", strb, 6'b000100);
    cyc();
    #1;
    chk("fetch2_rd", strb, 6'b000100);
    cyc();
    do_fetch(10'h05A);

    // LDI rsel=01
    #1;
    chk("ldi_strb",    strb,    6'b000001);
    chk("ldi_reg_sel", reg_sel, 2'b01);
    chk("ldi_alu_op",  alu_op,  3'b000);
    cyc();
    #1;
    chk("ldi_to_fetch", strb, 6'b000100);

    // ADD rsel=11
    do_fetch(10'h0B0);
    #1;
    chk("add_strb",    strb,    6'b000001);
    chk("add_reg_sel", reg_sel, 2'b11);
    chk("add_alu_op",  alu_op,  3'b001);
    cyc();

    // OR rsel=10
    do_fetch(10'h160);
    #1;
    chk("or_reg_sel", reg_sel, 2'b10);
    chk("or_alu_op",  alu_op,  3'b100);
    cyc();

    // JMP
    do_fetch(10'h180);
    #1;
    chk("jmp_strb", strb, 6'b001000);
    cyc();

    // JZ not taken, then taken
    do_fetch(10'h1C0);
    zero_flag = 1'b0;
    #1;
    chk("jz0_strb", strb, 6'b000000);
    cyc();
    do_fetch(10'h1C0);
    zero_flag = 1'b1;
    #1;
    chk("jz1_strb", strb, 6'b001000);
    cyc();
    zero_flag = 1'b0;
    #1;
    chk("jz1_one_cycle", strb, 6'b000100);

    // LD rsel=01, mem_ready delayed 4 cycles
    do_fetch(10'h210);
    #1;
    chk("ld_exec", strb, 6'b000000);
    for (int k = 0; k < 4; k++) begin
      cyc();
      #1;
      chk("ld_wait", strb, 6'b000100);
    end
    cyc();
    mem_ready = 1'b1;
    #1;
    chk("ld_done",    strb,    6'b000101);
    chk("ld_reg_sel", reg_sel, 2'b01);
    cyc();
    mem_ready = 1'b0;
    #1;
    chk("ld_to_fetch", strb, 6'b000100);

    // ST
    do_fetch(10'h240);
    #1;
    chk("st_exec", strb, 6'b000000);
    cyc();
    #1;
    chk("st_wait", strb, 6'b000010);
    mem_ready = 1'b1;
    #1;
    chk("st_done", strb, 6'b000010);
    cyc();
    mem_ready = 1'b0;
    #1;
    chk("st_to_fetch", strb, 6'b000100);

    // Illegal opcode A: flag set, execution continues
    do_fetch(10'h280);
    #1;
    chk("ill_exec", strb, 6'b000000);
    cyc();
    #1;
    chk("ill_flag",     illegal, 1'b1);
    chk("ill_continue", strb,    6'b000100);

    // HLT
    do_fetch(10'h3C0);
    #1;
    chk("hlt_exec", {strb, halted}, 7'b0000000);
    cyc();
    #1;
    chk("hlt_flag", halted, 1'b1);
    mem_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      #1;
      chk("hlt_frozen", strb, 6'b000000);
      cyc();
    end
    chk("hlt_ill_sticky", illegal, 1'b1);
    mem_ready = 1'b0;

    // Reset clears sticky flags
    rst = 1'b0;
    cyc();
    #1;
    chk("rst2_flags", {halted, illegal, bus_err}, 3'b000);
    rst = 1'b1;
    cyc();

    // Timeout: mem_ready stuck low in FETCH
    for (int k = 0; k < 15; k++) begin
      #1;
      chk("to_rd_held", strb, 6'b000100);
      chk("to_no_err",  bus_err, 1'b0);
      cyc();
    end
    #1;
    chk("to_drop_req", strb, 6'b000000);
    cyc();
    #1;
    chk("to_bus_err", bus_err, 1'b1);
    chk("to_halted_quiet", strb, 6'b000000);
    mem_ready = 1'b1;
    #1;
    chk("to_halt_ignores_ready", strb, 6'b000000);
    mem_ready = 1'b0;
    rst = 1'b0;
    cyc();
    #1;
    chk("to_rst_clears", bus_err, 1'b0);
    rst = 1'b1;
    cyc();

    // Reset in MEM abandons the load
    do_fetch(10'h210);
    cyc();
    #1;
    chk("rmem_rd", strb, 6'b000100);
    rst = 1'b0;
    cyc();
    mem_ready = 1'b1;
    #1;
    chk("rmem_abandon", strb, 6'b000000);
    mem_ready = 1'b0;
    rst = 1'b1;
    cyc();
    #1;
    chk("rmem_refetch", strb, 6'b000100);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
